// File: rtl/ram_write_ctrl.sv
// Write-port front end for the RAM system: synchronizes the raw switches and key,
// debounces the key, and issues one wr_en strobe per press with captured address/data.
module ram_write_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ADDR_W          = 5,
  parameter int DATA_W          = 4,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_n,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              key_pressed,
  output logic [CNT_W-1:0]  write_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ARM, FIRE, HELD, DISARM} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic              capture, bump;

  logic              key_meta, key_s;
  logic [ADDR_W-1:0] addr_meta, addr_s;
  logic [DATA_W-1:0] data_meta, data_s;

  // Key flops reset to 1 so a reset looks like a released key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta  <= 1'b1;
      key_s     <= 1'b1;
      addr_meta <= '0;
      addr_s    <= '0;
      data_meta <= '0;
      data_s    <= '0;
    end else begin
      key_meta  <= key_n;
      key_s     <= key_meta;
      addr_meta <= sw_addr;
      addr_s    <= addr_meta;
      data_meta <= sw_data;
      data_s    <= data_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      write_count <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        wr_addr <= addr_s;
        wr_data <= data_s;
      end
      if (bump) write_count <= write_count + CNT_W'(1);
    end
  end

  // Press and release are each debounced by a full run of stable cycles.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    bump       = 1'b0;
    case (state)
      IDLE: begin
        if (!key_s) begin
          state_next = ARM;
          cnt_next   = '0;
        end
      end
      ARM: begin
        if (key_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = FIRE;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      FIRE: begin
        state_next = HELD;
        bump       = 1'b1;
      end
      HELD: begin
        if (key_s) begin
          state_next = DISARM;
          cnt_next   = '0;
        end
      end
      DISARM: begin
        if (!key_s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign wr_en       = (state == FIRE);
  assign key_pressed = (state == FIRE) || (state == HELD) || (state == DISARM);

endmodule

// File: tb/tb_ram_write_ctrl.sv
// Directed bench for ram_write_ctrl with a 4-cycle debounce; a second instance with a
// 2-bit write counter shares the same inputs to exercise counter wrap.
module tb_ram_write_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_n;
  logic [4:0] sw_addr;
  logic [3:0] sw_data;

  logic       wr_en, key_pressed;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] write_count;

  logic       wr_en_n, key_pressed_n;
  logic [4:0] wr_addr_n;
  logic [3:0] wr_data_n;
  logic [1:0] write_count_n;

  int errors = 0;
  int checks = 0;

  ram_write_ctrl #(.DEBOUNCE_CYCLES(4), .ADDR_W(5), .DATA_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw_addr(sw_addr), .sw_data(sw_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .key_pressed(key_pressed), .write_count(write_count)
  );

  ram_write_ctrl #(.DEBOUNCE_CYCLES(4), .ADDR_W(5), .DATA_W(4), .CNT_W(2)) dut_narrow (
    .clk(clk), .reset(reset), .key_n(key_n), .sw_addr(sw_addr), .sw_data(sw_data),
    .wr_en(wr_en_n), .wr_addr(wr_addr_n), .wr_data(wr_data_n),
    .key_pressed(key_pressed_n), .write_count(write_count_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       key_n;
    logic [4:0] sw_addr;
    logic [3:0] sw_data;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [3:0] wr_data;
    logic       key_pressed;
    logic [7:0] write_count;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs n edges, sampling #1 after each; counts strobes and notes the first strobe edge.
  task automatic run(input int n, output int strobes, output int first);
    strobes = 0;
    first   = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (wr_en) begin
        if (first < 0) first = i;
        strobes++;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wr_en"}, wr_en, 0);
    check({tag, " wr_addr"}, wr_addr, 0);
    check({tag, " wr_data"}, wr_data, 0);
    check({tag, " key_pressed"}, key_pressed, 0);
    check({tag, " write_count"}, write_count, 0);
    check({tag, " narrow write_count"}, write_count_n, 0);
    check({tag, " narrow wr_addr"}, wr_addr_n, 0);
    check({tag, " narrow wr_data"}, wr_data_n, 0);
    check({tag, " narrow wr_en"}, wr_en_n, 0);
    check({tag, " narrow key_pressed"}, key_pressed_n, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s, f, tot;

    // Clean press from idle: key sampled low at edge 0, strobe after edge 6.
    for (int i = 0; i < 12; i++) begin
      vecs[i] = '{1'b0, 5'h0A, 4'h9, 1'b0, 5'h00, 4'h0, 1'b0, 8'd0};
      if (i == 6) vecs[i] = '{1'b0, 5'h0A, 4'h9, 1'b1, 5'h0A, 4'h9, 1'b1, 8'd0};
      if (i > 6)  vecs[i] = '{1'b0, 5'h0A, 4'h9, 1'b0, 5'h0A, 4'h9, 1'b1, 8'd1};
    end

    reset = 1'b1; key_n = 1'b1; sw_addr = '0; sw_data = '0;
    #2;
    check_all_zero("reset at t0");
    run(2, s, f);
    reset = 1'b0;
    run(20, s, f);
    check("idle strobes", s, 0);
    check("idle write_count", write_count, 0);

    for (int i = 0; i < 12; i++) begin
      key_n = vecs[i].key_n; sw_addr = vecs[i].sw_addr; sw_data = vecs[i].sw_data;
      @(posedge clk);
      #1;
      check($sformatf("press[%0d] wr_en", i), wr_en, vecs[i].wr_en);
      check($sformatf("press[%0d] wr_addr", i), wr_addr, vecs[i].wr_addr);
      check($sformatf("press[%0d] wr_data", i), wr_data, vecs[i].wr_data);
      check($sformatf("press[%0d] key_pressed", i), key_pressed, vecs[i].key_pressed);
      check($sformatf("press[%0d] write_count", i), write_count, vecs[i].write_count);
    end

    key_n = 1'b1;
    run(10, s, f);
    check("release strobes", s, 0);
    check("release key_pressed", key_pressed, 0);

    // Glitch: three low samples never complete the press debounce.
    key_n = 1'b0;
    run(3, s, f); tot = s;
    key_n = 1'b1;
    run(20, s, f); tot += s;
    check("glitch strobes", tot, 0);
    check("glitch write_count", write_count, 1);
    check("glitch key_pressed", key_pressed, 0);

    // Bounce during hold; the fresh press latency also shows the FSM was back in IDLE.
    key_n = 1'b0;
    run(10, s, f);
    check("bounce first strobe edge", f, 6);
    tot = s;
    key_n = 1'b1; run(1, s, f); tot += s;
    key_n = 1'b0; run(1, s, f); tot += s;
    key_n = 1'b1; run(1, s, f); tot += s;
    key_n = 1'b0; run(30, s, f); tot += s;
    check("bounce total strobes", tot, 1);
    check("bounce write_count", write_count, 2);
    check("bounce key_pressed", key_pressed, 1);
    key_n = 1'b1;
    run(10, s, f);
    check("bounce release strobes", s, 0);

    // Data capture isolation.
    sw_addr = 5'h03; sw_data = 4'h2; key_n = 1'b0;
    run(7, s, f);
    check("capture strobe edge", f, 6);
    check("capture wr_data on strobe", wr_data, 4'h2);
    run(1, s, f);
    sw_data = 4'h7;
    run(10, s, f);
    check("capture no extra strobe", s, 0);
    check("capture wr_data held", wr_data, 4'h2);
    key_n = 1'b1;
    run(10, s, f);
    check("capture wr_data after release", wr_data, 4'h2);
    check("capture write_count", write_count, 3);
    key_n = 1'b0;
    run(12, s, f);
    check("second press strobes", s, 1);
    check("second press wr_data", wr_data, 4'h7);
    check("second press wr_addr", wr_addr, 5'h03);
    check("second press write_count", write_count, 4);
    check("narrow write_count before reset", write_count_n, 0);
    key_n = 1'b1;
    run(10, s, f);

    // Reset asserted between edges while in ARM with cnt=2.
    key_n = 1'b0;
    run(5, s, f);
    check("pre-reset strobes", s, 0);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("reset mid-ARM");
    run(2, s, f);
    check("strobes during reset", s, 0);
    reset = 1'b0;
    run(12, s, f);
    check("held-through-reset strobes", s, 1);
    check("held-through-reset strobe edge", f, 6);
    check("held-through-reset write_count", write_count, 1);
    check("held-through-reset wr_addr", wr_addr, 5'h03);

    // Three more presses take the 2-bit counter through its wrap.
    for (int p = 0; p < 3; p++) begin
      key_n = 1'b1; run(10, s, f);
      key_n = 1'b0; run(12, s, f);
      check($sformatf("wrap press %0d strobes", p), s, 1);
      if (p == 1) check("narrow write_count at 3", write_count_n, 2'd3);
    end
    check("wide write_count after 4", write_count, 4);
    check("narrow write_count wrapped", write_count_n, 0);

    key_n = 1'b1;
    run(10, s, f);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
